pll_clken_gen: RTL and testbench
================================

# pll_clken_gen

Parametrised multi-channel clock-enable and divided-clock generator with lock supervision. It sits directly behind the board PLL output and derives up to 8 phase-aligned divided clocks and single-cycle enables from one reference clock. Divide ratio and phase offset are runtime-reconfigurable per channel. A `locked` indication qualifies downstream OFDM datapath blocks, the same way the PLL lock output does.

## Interface
- `NUM_CLOCKS`, 2: number of output channels, 1..8.
- `CNT_W`, 8: width of each per-channel divide and phase field.
- `LOCK_CYCLES`, 16: number of refclk cycles spent in LOCKING before `locked` asserts, ≥2.
- `DEFAULT_DIV`, 2: divide ratio loaded into every channel at reset. Default phase is 0.
- `refclk`, in, 1: the only clock; rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `cfg_valid`, in, 1: new configuration offered.
- `cfg_ready`, out, 1: configuration accepted when high together with `cfg_valid`.
- `cfg_div`, in, `NUM_CLOCKS*CNT_W`: channel i divide ratio N in bits [i*CNT_W +: CNT_W]. N=0 disables the channel.
- `cfg_phase`, in, `NUM_CLOCKS*CNT_W`: channel i start offset P in cycles.
- `outclk_en`, out, `NUM_CLOCKS`: single-cycle enable pulse, one per N refclk cycles.
- `outclk`, out, `NUM_CLOCKS`: registered divided clock.
- `locked`, out, 1: outputs valid and stable.

## Operation
- FSM states are LOCKING and LOCKED. Reset enters LOCKING, with `lock_cnt`=0 and every channel loaded with N=`DEFAULT_DIV`, P=0.
- **LOCKING:**
  - `lock_cnt` increments every cycle.
  - When `lock_cnt`==`LOCK_CYCLES-1`, the FSM moves to LOCKED on the next edge.
  - Channel counters are held at their start value.
  - `outclk`, `outclk_en`, `locked` and `cfg_ready` are all 0.
- **LOCKED:**
  - `locked`=1 and `cfg_ready`=1.
  - Each enabled channel counter `cnt` starts at P' = min(P, N-1) and counts up, wrapping from N-1 to 0.
- **Handshake:**
  - Transfer occurs when `cfg_valid` && `cfg_ready`.
  - On a transfer, the `cfg_div` and `cfg_phase` vectors are latched.
  - The FSM returns to LOCKING with `lock_cnt`=0. `locked` and `cfg_ready` drop on the next edge.
  - `cfg_valid` in LOCKING is ignored; it is not queued.
- **Per channel, while LOCKED:**
  - `outclk_en[i]` = (N≠0) && (cnt==0).
  - `outclk[i]` = (N≠0) && (cnt < ceil(N/2)).
  - Consequences: 50% duty for even N; high one extra cycle for odd N; N=1 gives `outclk`=1 constant and `outclk_en`=1 every cycle.
- **Disabled channel (N=0):** `cnt` is held at 0 and both outputs stay at 0.
- **Phase clamp:** P ≥ N is clamped to N-1; no error is flagged.
- **Reset mid-operation:** asserting `rst_n` low asynchronously clears all outputs to 0 and restores the defaults. Any latched configuration is lost.

## Timing
- Reset values: `locked`=0, `cfg_ready`=0, `outclk`=0, `outclk_en`=0, FSM=LOCKING, `lock_cnt`=0, N=`DEFAULT_DIV`, P=0.
- `outclk`, `outclk_en` and `locked` are driven directly from flops; there is no combinational path from any input.
- The output value in a cycle corresponds to the counter value in that same cycle. This is achieved by computing the flop next-state from the next counter value.
- **Lock latency:** `locked` rises on the `LOCK_CYCLES`-th rising edge after `rst_n` deasserts, or after an accepting edge.
- **First cycle with `locked`=1:** `cnt`=P'. The first `outclk_en` pulse therefore occurs (N-P') mod N cycles later; for P'=0 it is in the same cycle.
- **Phase alignment:** all channels leave LOCKING on the same edge, so their relative phase is exactly determined by the P' values.
- Counter arithmetic is unsigned `CNT_W`-bit. `ceil(N/2)` is computed as (N+1)>>1 at `CNT_W+1` bits to avoid overflow at N=2^`CNT_W`-1.

## Test plan
- **Reset/lock:** `NUM_CLOCKS`=2, `LOCK_CYCLES`=16, `DEFAULT_DIV`=2; release `rst_n` -> `locked`=0 for 15 edges and 1 at edge 16. Both `outclk` then toggle every cycle; `outclk_en` pulses every 2 cycles, aligned across channels.
- **Reconfigure:** in LOCKED, send div={3,4} (ch1,ch0) and phase={0,1} -> `cfg_ready` drops next cycle and `locked` is low for 16 cycles. Then ch0 shows pattern H,L,L,H from P=1 with its first `outclk_en` 3 cycles after lock. ch1 `outclk` is H,H,L with `outclk_en` in the first locked cycle.
- **Disable and N=1:** div={0,1} -> ch1 `outclk`=0 and `outclk_en`=0 permanently; ch0 `outclk`=1 and `outclk_en`=1 every locked cycle.
- **Phase clamp and width edge:** `CNT_W`=8, div0=255, phase0=300 mod 256=44 (<255, not clamped), then phase0=255 -> clamped to 254. Check period=255 with `outclk` high for 128 cycles.
- **`cfg_valid` in LOCKING:** pulse `cfg_valid` with new values during LOCKING -> ignored; outputs use the previously accepted configuration.
- **Async reset mid-run:** drop `rst_n` for less than one cycle while LOCKED -> all outputs go 0 immediately without a clock edge. After release, defaults relock in 16 cycles.

Source files
------------

// File: rtl/pll_clken_gen_if.sv
// Configuration handshake and divided-clock outputs of pll_clken_gen.
// The master side offers configurations; the slave side generates the clocks.
interface pll_clken_gen_if #(
  parameter int NUM_CLOCKS = 2,
  parameter int CNT_W      = 8
);
  logic                        cfg_valid;
  logic                        cfg_ready;
  logic [NUM_CLOCKS*CNT_W-1:0] cfg_div;
  logic [NUM_CLOCKS*CNT_W-1:0] cfg_phase;
  logic [NUM_CLOCKS-1:0]       outclk_en;
  logic [NUM_CLOCKS-1:0]       outclk;
  logic                        locked;

  modport master (
    output cfg_valid, cfg_div, cfg_phase,
    input  cfg_ready, outclk_en, outclk, locked
  );

  modport slave (
    input  cfg_valid, cfg_div, cfg_phase,
    output cfg_ready, outclk_en, outclk, locked
  );
endinterface

// File: rtl/pll_clken_gen.sv
// Multi-channel clock-enable / divided-clock generator with lock supervision.
// Every accepted reconfiguration relocks all channels together, so they stay phase-aligned.
module pll_clken_gen #(
  parameter int NUM_CLOCKS  = 2,
  parameter int CNT_W       = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int DEFAULT_DIV = 2
) (
  input logic             refclk,
  input logic             rst_n,
  pll_clken_gen_if.slave  cfg
);

  localparam int LCW = $clog2(LOCK_CYCLES);

  localparam logic [0:0]       ST_LOCKING = 1'b0;
  localparam logic [0:0]       ST_LOCKED  = 1'b1;
  localparam logic [LCW-1:0]   LOCK_LAST  = LCW'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_RST    = CNT_W'(DEFAULT_DIV);

  logic [0:0]            r_state;
  logic [0:0]            w_state_nxt;
  logic [LCW-1:0]        r_lock_cnt;
  logic                  r_locked;
  logic [NUM_CLOCKS-1:0] r_outclk;
  logic [NUM_CLOCKS-1:0] r_outclk_en;
  logic [NUM_CLOCKS-1:0] w_outclk_nxt;
  logic [NUM_CLOCKS-1:0] w_outclk_en_nxt;
  logic                  w_accept;
  logic                  w_locked_nxt;
  logic                  w_stay_locked;

  // cfg_ready is the locked flop itself, so a transfer can only happen while LOCKED.
  assign w_accept = cfg.cfg_valid && r_locked;

  // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOCKING: if (r_lock_cnt == LOCK_LAST) w_state_nxt = ST_LOCKED;
      ST_LOCKED:  if (w_accept)                w_state_nxt = ST_LOCKING;
      default:                                 w_state_nxt = ST_LOCKING;
    endcase
  end

  assign w_locked_nxt  = (w_state_nxt == ST_LOCKED);
  assign w_stay_locked = (r_state == ST_LOCKED) && w_locked_nxt;

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_LOCKING;
      r_lock_cnt  <= '0;
      r_locked    <= 1'b0;
      r_outclk    <= '0;
      r_outclk_en <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_lock_cnt  <= (r_state == ST_LOCKING && w_state_nxt == ST_LOCKING) ? r_lock_cnt + 1'b1 : '0;
      r_locked    <= w_locked_nxt;
      r_outclk    <= w_outclk_nxt;
      r_outclk_en <= w_outclk_en_nxt;
    end
  end

  for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_ch
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_start;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_div_in;
    logic [CNT_W-1:0] w_ph_in;
    logic [CNT_W-1:0] w_start_in;
    logic [CNT_W-1:0] w_div_nxt;
    logic [CNT_W-1:0] w_start_nxt;
    logic [CNT_W-1:0] w_wrap;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W:0]   w_half;

    assign w_div_in = cfg.cfg_div[i*CNT_W +: CNT_W];
    assign w_ph_in  = cfg.cfg_phase[i*CNT_W +: CNT_W];

    // Start value is clamped once at latch time; a disabled channel always starts at 0.
    assign w_start_in = (w_div_in == '0)      ? '0 :
                        (w_ph_in >= w_div_in) ? w_div_in - 1'b1 : w_ph_in;

    assign w_div_nxt   = w_accept ? w_div_in   : r_div;
    assign w_start_nxt = w_accept ? w_start_in : r_start;

    assign w_wrap    = (r_div == '0 || r_cnt == r_div - 1'b1) ? '0 : r_cnt + 1'b1;
    assign w_cnt_nxt = w_stay_locked ? w_wrap : w_start_nxt;

    // Extra bit keeps (N+1)>>1 exact at N = 2^CNT_W-1.
    assign w_half = ({1'b0, w_div_nxt} + 1'b1) >> 1;

    // Outputs are registered from the next counter value so they line up with the counter.
    assign w_outclk_nxt[i]    = w_locked_nxt && (w_div_nxt != '0) && ({1'b0, w_cnt_nxt} < w_half);
    assign w_outclk_en_nxt[i] = w_locked_nxt && (w_div_nxt != '0) && (w_cnt_nxt == '0);

    always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
        r_div   <= DIV_RST;
        r_start <= '0;
        r_cnt   <= '0;
      end else begin
        r_div   <= w_div_nxt;
        r_start <= w_start_nxt;
        r_cnt   <= w_cnt_nxt;
      end
    end
  end

  assign cfg.cfg_ready = r_locked;
  assign cfg.locked    = r_locked;
  assign cfg.outclk    = r_outclk;
  assign cfg.outclk_en = r_outclk_en;

endmodule

// File: tb/tb_pll_clken_gen.sv
// Scoreboard bench for pll_clken_gen: stimulus queues expected locked-cycle outputs,
// a negedge monitor pops and compares them whenever the DUT reports locked.
module tb_pll_clken_gen;
  localparam int NC = 2;
  localparam int CW = 8;
  localparam int LC = 16;
  localparam int DD = 2;

  typedef struct packed {
    logic [NC-1:0] clk;
    logic [NC-1:0] en;
  } exp_t;

  logic refclk = 1'b0;
  logic rst_n  = 1'b0;
  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 refclk = ~refclk;

  pll_clken_gen_if #(.NUM_CLOCKS(NC), .CNT_W(CW)) u_if ();

  pll_clken_gen #(
    .NUM_CLOCKS (NC),
    .CNT_W      (CW),
    .LOCK_CYCLES(LC),
    .DEFAULT_DIV(DD)
  ) u_dut (
    .refclk(refclk),
    .rst_n (rst_n),
    .cfg   (u_if)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected entry per locked cycle.
  always @(negedge refclk) begin
    exp_t e;
    if (u_if.locked === 1'b1 && q.size() > 0) begin
      e = q.pop_front();
      check("outclk", 32'(u_if.outclk), 32'(e.clk));
      check("outclk_en", 32'(u_if.outclk_en), 32'(e.en));
      check("cfg_ready_locked", 32'(u_if.cfg_ready), 32'd1);
    end
  end

  // Closed-form expectation: cnt = (P' + k) mod N, P' = min(P, N-1).
  task automatic push_model(input int n0, input int p0, input int n1, input int p1, input int cycles);
    int   n[2];
    int   p[2];
    exp_t e;
    n[0] = n0;
    n[1] = n1;
    p[0] = (n0 == 0) ? 0 : ((p0 >= n0) ? n0 - 1 : p0);
    p[1] = (n1 == 0) ? 0 : ((p1 >= n1) ? n1 - 1 : p1);
    for (int k = 0; k < cycles; k++) begin
      e = '0;
      for (int ch = 0; ch < NC; ch++) begin
        if (n[ch] != 0) begin
          int c;
          c = (p[ch] + k) % n[ch];
          e.clk[ch] = (c < (n[ch] + 1) / 2);
          e.en[ch]  = (c == 0);
        end
      end
      q.push_back(e);
    end
  endtask

  task automatic wait_lock(input int exp_edges);
    int n = 0;
    do begin
      @(negedge refclk);
      n++;
    end while (u_if.locked !== 1'b1 && n < 64);
    check("lock_latency", 32'(n), 32'(exp_edges));
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 2000) begin
      @(negedge refclk);
      #1;
      n++;
    end
    check("drain", 32'(q.size()), 32'd0);
  endtask

  // Called at negedge+1 while LOCKED; returns at the negedge after the accepting edge.
  task automatic send_cfg(input logic [15:0] div, input logic [15:0] phase);
    u_if.cfg_div   = div;
    u_if.cfg_phase = phase;
    u_if.cfg_valid = 1'b1;
    @(negedge refclk);
    u_if.cfg_valid = 1'b0;
    check("ready_drop", 32'(u_if.cfg_ready), 32'd0);
    check("locked_drop", 32'(u_if.locked), 32'd0);
  endtask

  initial begin
    logic [1:0] t2_clk [8];
    logic [1:0] t2_en  [8];
    t2_clk = '{2'b11, 2'b10, 2'b00, 2'b11, 2'b11, 2'b00, 2'b10, 2'b11};
    t2_en  = '{2'b10, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b10, 2'b01};

    u_if.cfg_valid = 1'b0;
    u_if.cfg_div   = '0;
    u_if.cfg_phase = '0;

    // Reset values
    #2;
    check("rst_locked", 32'(u_if.locked), 32'd0);
    check("rst_ready", 32'(u_if.cfg_ready), 32'd0);
    check("rst_outclk", 32'(u_if.outclk), 32'd0);
    check("rst_outclk_en", 32'(u_if.outclk_en), 32'd0);
    repeat (2) @(negedge refclk);
    rst_n = 1'b1;

    // Defaults: N=2, P=0 on both channels
    push_model(2, 0, 2, 0, 6);
    wait_lock(16);
    drain();

    // Reconfigure: ch1 N=3 P=0, ch0 N=4 P=1 (hand-computed pattern)
    send_cfg({8'd3, 8'd4}, {8'd0, 8'd1});
    for (int k = 0; k < 8; k++) q.push_back('{clk: t2_clk[k], en: t2_en[k]});
    wait_lock(16);
    drain();

    // Width edge: ch0 N=255 with P=300 mod 256=44, then P=255 clamped to 254
    send_cfg({8'd2, 8'd255}, {8'd0, 8'(300)});
    push_model(255, 44, 2, 0, 300);
    wait_lock(16);
    drain();
    send_cfg({8'd2, 8'd255}, {8'd0, 8'd255});
    push_model(255, 255, 2, 0, 300);
    wait_lock(16);
    drain();

    // ch1 disabled, ch0 N=1 (P=3 clamps to 0); cfg_valid pulsed during LOCKING is ignored
    send_cfg({8'd0, 8'd1}, {8'd7, 8'd3});
    push_model(1, 3, 0, 7, 20);
    repeat (4) begin
      u_if.cfg_div   = {8'd5, 8'd5};
      u_if.cfg_phase = '0;
      u_if.cfg_valid = 1'b1;
      @(negedge refclk);
      check("ready_in_locking", 32'(u_if.cfg_ready), 32'd0);
    end
    u_if.cfg_valid = 1'b0;
    wait_lock(12);
    drain();

    // Asynchronous reset pulse shorter than a cycle while LOCKED
    check("pre_rst_outclk", 32'(u_if.outclk), 32'b01);
    rst_n = 1'b0;
    #2;
    check("async_locked", 32'(u_if.locked), 32'd0);
    check("async_ready", 32'(u_if.cfg_ready), 32'd0);
    check("async_outclk", 32'(u_if.outclk), 32'd0);
    check("async_outclk_en", 32'(u_if.outclk_en), 32'd0);
    #1;
    rst_n = 1'b1;
    push_model(2, 0, 2, 0, 6);
    wait_lock(16);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
